// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared core types. Defines the execute-stage operand source
//               class and the retire destination class that
//               core_exec_dst_ctrl consumes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  // Operand source selection for the execute stage.
  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_IMM = 2'd1,
    SRC_PC  = 2'd2,
    SRC_CSR = 2'd3
  } exec_src_e;

  // Where an execute result is retired to. Encoding 3'd7 is unused and is
  // retired as DST_NONE.
  typedef enum logic [2:0] {
    DST_NONE    = 3'd0,
    DST_REG     = 3'd1,
    DST_CSR     = 3'd2,
    DST_PC      = 3'd3,
    DST_PC_LINK = 3'd4,
    DST_MEM     = 3'd5,
    DST_MEM_REG = 3'd6
  } exec_dst_e;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;

endpackage : core_pkg

`default_nettype wire

// File: rtl/core_exec_dst_ctrl.sv
// ============================================================================
// Module      : core_exec_dst_ctrl
// Description : Retires one execute result to its destination: register
//               file, CSR, PC, PC+link, store channel, or store followed by
//               a register write (AMO). One request in flight at a time.
// Ports       : clk, rstn (sync, active-low)
//               start, exec_dst, rd_idx, result, alt_data   - request
//               reg_we/reg_waddr/reg_wdata                  - regfile write
//               csr_we/csr_wdata, pc_we/pc_wdata            - CSR / PC write
//               mem_wvalid/mem_wready/mem_waddr/mem_wdata   - store channel
//               busy, done                                  - status
//               fwd_valid/fwd_idx/fwd_data                  - writeback fwd
// Config      : CORE_WB_FWD_EN - adds the writeback forwarding outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_exec_dst_ctrl
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  exec_dst_e   exec_dst,
  input  logic [4:0]  rd_idx,
  input  logic [31:0] result,
  input  logic [31:0] alt_data,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  output logic        pc_we,
  output logic [31:0] pc_wdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done
`ifdef CORE_WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_idx,
  output logic [31:0] fwd_data
`endif
);

  localparam logic [1:0] ST_IDLE          = 2'd0;
  localparam logic [1:0] ST_WRITE         = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT      = 2'd2;
  localparam logic [1:0] ST_REG_AFTER_MEM = 2'd3;

  logic [1:0]  state_q,      state_d;
  exec_dst_e   dst_q,        dst_d;
  logic [4:0]  rd_q,         rd_d;
  logic [31:0] alt_q,        alt_d;
  logic        busy_q,       busy_d;
  logic        done_q,       done_d;
  logic        reg_we_q,     reg_we_d;
  logic [4:0]  reg_waddr_q,  reg_waddr_d;
  logic [31:0] reg_wdata_q,  reg_wdata_d;
  logic        csr_we_q,     csr_we_d;
  logic [31:0] csr_wdata_q,  csr_wdata_d;
  logic        pc_we_q,      pc_we_d;
  logic [31:0] pc_wdata_q,   pc_wdata_d;
  logic        mem_wvalid_q, mem_wvalid_d;
  logic [31:0] mem_waddr_q,  mem_waddr_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;

  // A plain store retires in its handshake cycle, so done must follow
  // mem_wready combinationally; every other done is a registered pulse.
  logic w_store_ack;
  assign w_store_ack = (state_q == ST_MEM_WAIT) && (dst_q == DST_MEM) && mem_wready;

  always_comb begin
    state_d      = state_q;
    dst_d        = dst_q;
    rd_d         = rd_q;
    alt_d        = alt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    reg_we_d     = 1'b0;
    reg_waddr_d  = reg_waddr_q;
    reg_wdata_d  = reg_wdata_q;
    csr_we_d     = 1'b0;
    csr_wdata_d  = csr_wdata_q;
    pc_we_d      = 1'b0;
    pc_wdata_d   = pc_wdata_q;
    mem_wvalid_d = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dst_d       = exec_dst;
          rd_d        = rd_idx;
          alt_d       = alt_data;
          busy_d      = 1'b1;
          reg_waddr_d = rd_idx;
          // Non-memory strobes are computed at acceptance so they appear,
          // registered, in the single WRITE cycle.
          case (exec_dst)
            DST_REG: begin
              state_d     = ST_WRITE;
              done_d      = 1'b1;
              reg_we_d    = (rd_idx != 5'd0);
              reg_wdata_d = result;
            end
            DST_CSR: begin
              state_d     = ST_WRITE;
              done_d      = 1'b1;
              csr_we_d    = 1'b1;
              csr_wdata_d = result;
              reg_we_d    = (rd_idx != 5'd0);
              reg_wdata_d = alt_data;
            end
            DST_PC: begin
              state_d    = ST_WRITE;
              done_d     = 1'b1;
              pc_we_d    = 1'b1;
              pc_wdata_d = result;
            end
            DST_PC_LINK: begin
              state_d     = ST_WRITE;
              done_d      = 1'b1;
              pc_we_d     = 1'b1;
              pc_wdata_d  = result;
              reg_we_d    = (rd_idx != 5'd0);
              reg_wdata_d = alt_data;
            end
            DST_MEM, DST_MEM_REG: begin
              state_d      = ST_MEM_WAIT;
              mem_wvalid_d = 1'b1;
              mem_waddr_d  = result;
              mem_wdata_d  = alt_data;
            end
            default: begin
              state_d = ST_WRITE;
              done_d  = 1'b1;
            end
          endcase
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      ST_MEM_WAIT: begin
        if (mem_wready) begin
          if (dst_q == DST_MEM_REG) begin
            // AMO: the old memory value goes to rd one cycle later.
            state_d     = ST_REG_AFTER_MEM;
            done_d      = 1'b1;
            reg_we_d    = (rd_q != 5'd0);
            reg_waddr_d = rd_q;
            reg_wdata_d = alt_q;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          mem_wvalid_d = 1'b1;
        end
      end

      ST_REG_AFTER_MEM: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      dst_q        <= DST_NONE;
      rd_q         <= 5'd0;
      alt_q        <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_waddr_q  <= 5'd0;
      reg_wdata_q  <= 32'd0;
      csr_we_q     <= 1'b0;
      csr_wdata_q  <= 32'd0;
      pc_we_q      <= 1'b0;
      pc_wdata_q   <= 32'd0;
      mem_wvalid_q <= 1'b0;
      mem_waddr_q  <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      dst_q        <= dst_d;
      rd_q         <= rd_d;
      alt_q        <= alt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      reg_we_q     <= reg_we_d;
      reg_waddr_q  <= reg_waddr_d;
      reg_wdata_q  <= reg_wdata_d;
      csr_we_q     <= csr_we_d;
      csr_wdata_q  <= csr_wdata_d;
      pc_we_q      <= pc_we_d;
      pc_wdata_q   <= pc_wdata_d;
      mem_wvalid_q <= mem_wvalid_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign reg_we     = reg_we_q;
  assign reg_waddr  = reg_waddr_q;
  assign reg_wdata  = reg_wdata_q;
  assign csr_we     = csr_we_q;
  assign csr_wdata  = csr_wdata_q;
  assign pc_we      = pc_we_q;
  assign pc_wdata   = pc_wdata_q;
  assign mem_wvalid = mem_wvalid_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q | w_store_ack;

`ifdef CORE_WB_FWD_EN
  // Loaded on the same edge as reg_we so the forwarded value is visible in
  // the write cycle itself. reg_we_d already excludes x0.
  logic        fwd_valid_q;
  logic [4:0]  fwd_idx_q;
  logic [31:0] fwd_data_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= 5'd0;
      fwd_data_q  <= 32'd0;
    end else if (reg_we_d) begin
      fwd_valid_q <= 1'b1;
      fwd_idx_q   <= reg_waddr_d;
      fwd_data_q  <= reg_wdata_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_idx   = fwd_idx_q;
  assign fwd_data  = fwd_data_q;
`endif

endmodule : core_exec_dst_ctrl

`default_nettype wire

// File: tb/tb_core_exec_dst_ctrl.sv
// ============================================================================
// Module      : tb_core_exec_dst_ctrl
// Description : Self-checking bench for core_exec_dst_ctrl. Expected strobes
//               and payloads come from a destination rule table; a small
//               model tracks the last non-x0 register write for forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_exec_dst_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  exec_dst_e   exec_dst;
  logic [4:0]  rd_idx;
  logic [31:0] result;
  logic [31:0] alt_data;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
`ifdef CORE_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  core_exec_dst_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .exec_dst   (exec_dst),
    .rd_idx     (rd_idx),
    .result     (result),
    .alt_data   (alt_data),
    .reg_we     (reg_we),
    .reg_waddr  (reg_waddr),
    .reg_wdata  (reg_wdata),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .pc_we      (pc_we),
    .pc_wdata   (pc_wdata),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done)
`ifdef CORE_WB_FWD_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_idx    (fwd_idx),
    .fwd_data   (fwd_data)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Forwarding model: last non-x0 register write.
  logic        fm_valid;
  logic [4:0]  fm_idx;
  logic [31:0] fm_data;

  wire [5:0] flags = {reg_we, csr_we, pc_we, mem_wvalid, done, busy};

  // One complete request. Inputs change and outputs are sampled at negedge.
  task automatic run_txn(input exec_dst_e d, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] alt,
                         input int wait_n, input bit inject, input string tag);
    logic        is_mem, wr_reg, cs, pc;
    logic [31:0] wdat;
    logic [5:0]  exp_f;
    is_mem = (d == DST_MEM) || (d == DST_MEM_REG);
    wr_reg = 1'b0; cs = 1'b0; pc = 1'b0; wdat = alt;
    case (d)
      DST_REG:     begin wr_reg = 1'b1; wdat = res; end
      DST_CSR:     begin wr_reg = 1'b1; cs = 1'b1; end
      DST_PC:      pc = 1'b1;
      DST_PC_LINK: begin wr_reg = 1'b1; pc = 1'b1; end
      DST_MEM_REG: wr_reg = 1'b1;
      default:     ;
    endcase
    if (rd == 5'd0) wr_reg = 1'b0;

    start = 1'b1; exec_dst = d; rd_idx = rd; result = res; alt_data = alt;
    mem_wready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (inject) begin
      // A second request while busy must be ignored.
      start    = 1'b1;
      exec_dst = exec_dst_e'(3'($urandom_range(0, 6)));
      rd_idx   = 5'($urandom);
      result   = $urandom;
      alt_data = $urandom;
    end

    if (!is_mem) begin
      exp_f = {wr_reg, cs, pc, 1'b0, 1'b1, 1'b1};
      vectors++;
      if (flags !== exp_f) begin
        miscompares++;
        $display("FAIL %s flags: got %b expected %b", tag, flags, exp_f);
      end
      if (wr_reg) begin
        vectors++;
        if ({reg_waddr, reg_wdata} !== {rd, wdat}) begin
          miscompares++;
          $display("FAIL %s reg payload: got %0d/%h expected %0d/%h", tag, reg_waddr, reg_wdata, rd, wdat);
        end
        fm_valid = 1'b1; fm_idx = rd; fm_data = wdat;
      end
      if (cs) begin
        vectors++;
        if (csr_wdata !== res) begin
          miscompares++;
          $display("FAIL %s csr_wdata: got %h expected %h", tag, csr_wdata, res);
        end
      end
      if (pc) begin
        vectors++;
        if (pc_wdata !== res) begin
          miscompares++;
          $display("FAIL %s pc_wdata: got %h expected %h", tag, pc_wdata, res);
        end
      end
      @(negedge clk);
      start = 1'b0;
    end else begin
      for (int i = 0; i < wait_n; i++) begin
        vectors++;
        if (flags !== 6'b000101 || mem_waddr !== res || mem_wdata !== alt) begin
          miscompares++;
          $display("FAIL %s wait%0d: got flags %b addr %h data %h expected 000101 %h %h",
                   tag, i, flags, mem_waddr, mem_wdata, res, alt);
        end
        @(negedge clk);
        start = 1'b0;
      end
      mem_wready = 1'b1;
      #1;
      exp_f = {3'b000, 1'b1, (d == DST_MEM), 1'b1};
      vectors++;
      if (flags !== exp_f || mem_waddr !== res || mem_wdata !== alt) begin
        miscompares++;
        $display("FAIL %s handshake: got flags %b addr %h data %h expected %b %h %h",
                 tag, flags, mem_waddr, mem_wdata, exp_f, res, alt);
      end
      @(negedge clk);
      mem_wready = 1'b0;
      start      = 1'b0;
      if (d == DST_MEM_REG) begin
        exp_f = {wr_reg, 5'b00011};
        vectors++;
        if (flags !== exp_f) begin
          miscompares++;
          $display("FAIL %s amo flags: got %b expected %b", tag, flags, exp_f);
        end
        if (wr_reg) begin
          vectors++;
          if ({reg_waddr, reg_wdata} !== {rd, alt}) begin
            miscompares++;
            $display("FAIL %s amo payload: got %0d/%h expected %0d/%h", tag, reg_waddr, reg_wdata, rd, alt);
          end
          fm_valid = 1'b1; fm_idx = rd; fm_data = alt;
        end
        @(negedge clk);
      end
    end

    vectors++;
    if (flags !== 6'b0) begin
      miscompares++;
      $display("FAIL %s idle after: got flags %b expected 000000", tag, flags);
    end
`ifdef CORE_WB_FWD_EN
    vectors++;
    if ({fwd_valid, fwd_idx, fwd_data} !== {fm_valid, fm_idx, fm_data}) begin
      miscompares++;
      $display("FAIL %s fwd: got %b/%0d/%h expected %b/%0d/%h", tag,
               fwd_valid, fwd_idx, fwd_data, fm_valid, fm_idx, fm_data);
    end
`endif
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; exec_dst = DST_REG; rd_idx = 5'd4;
    result = 32'hAAAA_5555; alt_data = 32'h1234_5678; mem_wready = 1'b0;
    fm_valid = 1'b0; fm_idx = 5'd0; fm_data = 32'd0;
    repeat (2) @(negedge clk);
    vectors++;
    if (flags !== 6'b0) begin
      miscompares++;
      $display("FAIL reset flags: got %b expected 000000", flags);
    end
    vectors++;
    if ({reg_waddr, reg_wdata, csr_wdata, pc_wdata, mem_waddr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset payload: got %h/%h/%h/%h/%h/%h expected all 0",
               reg_waddr, reg_wdata, csr_wdata, pc_wdata, mem_waddr, mem_wdata);
    end
    start = 1'b0; rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (flags !== 6'b0) begin
      miscompares++;
      $display("FAIL reset release: got %b expected 000000", flags);
    end
  endtask

  task automatic test_directed();
    run_txn(DST_REG,     5'd5, 32'h0000_1234, 32'h0,         0, 1'b0, "reg");
    run_txn(DST_MEM,     5'd2, 32'h8000_0010, 32'hDEAD_BEEF, 3, 1'b0, "mem");
    run_txn(DST_MEM_REG, 5'd7, 32'h8000_0020, 32'h0000_0055, 1, 1'b0, "amo");
    run_txn(DST_CSR,     5'd0, 32'h0000_0008, 32'h0000_0003, 0, 1'b0, "csr_x0");
    run_txn(DST_PC,      5'd9, 32'h0000_4000, 32'h0000_0777, 0, 1'b0, "pc");
    run_txn(DST_PC_LINK, 5'd1, 32'h0000_5000, 32'h0000_0104, 0, 1'b0, "pc_link");
    run_txn(DST_NONE,    5'd6, 32'h1,         32'h2,         0, 1'b0, "none");
    run_txn(exec_dst_e'(3'd7), 5'd6, 32'h3,   32'h4,         0, 1'b0, "undef");
    run_txn(DST_REG,     5'd0, 32'hFFFF_FFFF, 32'h0,         0, 1'b0, "reg_x0");
`ifdef CORE_WB_FWD_EN
    run_txn(DST_REG,     5'd3, 32'h0000_0042, 32'h0,         0, 1'b0, "fwd");
`endif
  endtask

  task automatic test_back_to_back();
    run_txn(DST_REG,     5'd11, 32'hCAFE_0001, 32'h0,         0, 1'b1, "b2b_reg");
    run_txn(DST_MEM,     5'd0,  32'h0000_0100, 32'h0BAD_F00D, 2, 1'b1, "b2b_mem");
    run_txn(DST_MEM_REG, 5'd12, 32'h0000_0200, 32'h0000_9999, 0, 1'b1, "b2b_amo");
  endtask

  task automatic test_reset_mid_mem();
    start = 1'b1; exec_dst = DST_MEM; rd_idx = 5'd3;
    result = 32'h8000_0040; alt_data = 32'h1111_2222; mem_wready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (mem_wvalid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mem pre: got wvalid %b busy %b expected 1 1", mem_wvalid, busy);
    end
    rstn = 1'b0; start = 1'b1; exec_dst = DST_REG; rd_idx = 5'd9;
    @(negedge clk);
    fm_valid = 1'b0; fm_idx = 5'd0; fm_data = 32'd0;
    vectors++;
    if (flags !== 6'b0 || mem_waddr !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mem abandon: got flags %b addr %h expected 000000 0", flags, mem_waddr);
    end
    @(negedge clk);
    vectors++;
    if (flags !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_mem start_in_reset: got flags %b expected 000000", flags);
    end
    rstn = 1'b1; start = 1'b0;
    @(negedge clk);
    vectors++;
    if (flags !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_mem release: got flags %b expected 000000", flags);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      exec_dst_e   d;
      logic [4:0]  rd;
      d  = exec_dst_e'(3'($urandom_range(0, 7)));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_txn(d, rd, $urandom, $urandom, $urandom_range(0, 3),
              bit'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_mem();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_core_exec_dst_ctrl

`default_nettype wire

// File: doc/core_exec_dst_ctrl.md
CORE_EXEC_DST_CTRL -- requirements
Module: core_exec_dst_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; rstn  in  1  reset, synchronous, active-low.
REQ-002 SHALL have ports: start  in  1  one-cycle request to retire an exec result; exec_dst  in  core_pkg::exec_dst_e  destination class; rd_idx  in  5  register destination.
REQ-003 SHALL have ports: result  in  32  ALU result (write value or store address); alt_data  in  32  secondary value (store data, old CSR value, AMO old memory value).
REQ-004 SHALL have ports: reg_we  out  1; reg_waddr  out  5; reg_wdata  out  32  register-file write strobe and payload.
REQ-005 SHALL have ports: csr_we  out  1; csr_wdata  out  32; pc_we  out  1; pc_wdata  out  32.
REQ-006 SHALL have ports: mem_wvalid  out  1; mem_wready  in  1; mem_waddr  out  32; mem_wdata  out  32  valid/ready store channel.
REQ-007 SHALL have ports: busy  out  1  request in flight; done  out  1  one-cycle retire pulse.

Function
REQ-008 SHALL accept start only when busy=0; start while busy=1 SHALL be ignored with no state change.
REQ-009 SHALL latch exec_dst, rd_idx, result, alt_data on accepted start; busy SHALL be 1 from the following cycle until the cycle after done.
REQ-010 SHALL implement states IDLE, WRITE, MEM_WAIT, REG_AFTER_MEM.
REQ-011 DST_REG: IDLE->WRITE; in WRITE assert reg_we with reg_wdata=result for one cycle, done=1, ->IDLE.
REQ-012 DST_CSR: in WRITE assert csr_we (csr_wdata=result) and reg_we (reg_wdata=alt_data) in the same cycle, done=1.
REQ-013 DST_PC: in WRITE assert pc_we with pc_wdata=result, done=1; reg_we SHALL stay 0.
REQ-014 DST_PC_LINK: in WRITE assert pc_we (pc_wdata=result) and reg_we (reg_wdata=alt_data, the link address) in the same cycle, done=1.
REQ-015 DST_MEM: IDLE->MEM_WAIT; mem_wvalid=1, mem_waddr=result, mem_wdata=alt_data held stable until mem_wready=1; done=1 in the handshake cycle, ->IDLE.
REQ-016 DST_MEM_REG (AMO): MEM_WAIT as REQ-015 without done; on handshake ->REG_AFTER_MEM; there reg_we=1, reg_wdata=alt_data, done=1, ->IDLE.
REQ-017 DST_NONE: IDLE->WRITE with no strobe, done=1.
REQ-018 reg_we SHALL be suppressed whenever rd_idx=0; done timing SHALL be unchanged.
REQ-019 Latency: non-memory destinations SHALL retire exactly 1 cycle after start; memory destinations 1 cycle plus wready wait; AMO one further cycle.
REQ-020 Outputs SHALL be registered; no input-to-output combinational path except mem_wready to done.
REQ-021 Undefined exec_dst SHALL behave as DST_NONE.

Reset
REQ-022 rstn=0 at a clock edge SHALL force IDLE, busy=0, done=0 and all strobes/valids to 0, payload outputs to 0, including mid-MEM_WAIT (store abandoned).
REQ-023 start SHALL be ignored in any cycle where rstn=0.

Configuration
REQ-024 With CORE_WB_FWD_EN defined, SHALL add outputs fwd_valid (1), fwd_idx (5), fwd_data (32), holding the last non-x0 register write and updated in the cycle reg_we=1; reset to 0.
REQ-025 Without CORE_WB_FWD_EN, fwd ports SHALL not exist and behaviour SHALL otherwise be identical.

Structure
REQ-026 exec_dst_e (DST_NONE, DST_REG, DST_CSR, DST_PC, DST_PC_LINK, DST_MEM, DST_MEM_REG) SHALL live in core_pkg beside exec_src_e; state enum SHALL be local.
REQ-027 Single module; no sub-module.

Verification
REQ-028 start, DST_REG, rd_idx=5, result=0x1234 -> next cycle reg_we=1, reg_waddr=5, reg_wdata=0x1234, done=1.
REQ-029 DST_MEM, result=0x8000_0010, alt_data=0xDEADBEEF, wready low 3 cycles -> mem_wvalid held 4 cycles with stable payload; done with handshake.
REQ-030 DST_MEM_REG, rd_idx=7, alt_data=0x55 -> store handshake then next cycle reg_we=1, reg_wdata=0x55, done=1.
REQ-031 DST_CSR, rd_idx=0, result=0x8, alt_data=0x3 -> csr_we=1, csr_wdata=0x8, reg_we=0, done=1.
REQ-032 rstn=0 during MEM_WAIT -> next cycle mem_wvalid=0, busy=0; second start during busy ignored.
REQ-033 With CORE_WB_FWD_EN: DST_REG rd_idx=3, result=0x42 -> fwd_valid=1, fwd_idx=3, fwd_data=0x42.
